fpu_addsub_arbiter: RTL and testbench
=====================================

# fpu_addsub_arbiter

Shares one combinational `Adder_Subtractor` (IEEE-754 single precision, ports `a`, `b`, `op`, `exception`, `result`) among `NREQ` requesters. The block contains a round-robin arbiter, an operand capture register, a three-state sequencer and a registered response channel with requester ID. It sits between the fixed-to-float converters (`fixed_float`) and downstream consumers, and is the single entry point to the FPU add/sub datapath.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the response ID.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept, one-hot or zero.
- `req_a`  in  NREQ x 32: operand A, IEEE-754 single.
- `req_b`  in  NREQ x 32: operand B, IEEE-754 single.
- `req_op`  in  NREQ: 0 = add, 1 = subtract (A−B).
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_result`  out  32: registered `result`.
- `rsp_exception`  out  1: registered `exception`.
- `rsp_id`  out  IDW: index of the requester that was served.
- `busy`  out  1: high when the state is not IDLE.
- `exc_count`  out  16: count of responses with the exception flag set; saturates at 0xFFFF.

## Operation
- FSM has three states: IDLE, EXEC, DONE.
- **IDLE**
  - The arbiter picks the first requester i with `req_valid[i]` high, searching from pointer `ptr` upward and wrapping mod NREQ.
  - `req_ready[i]` is driven high combinationally for that requester only.
  - When `req_valid[i] & req_ready[i]`, the block latches `req_a[i]`, `req_b[i]`, `req_op[i]` and i, sets `ptr` to (i+1) mod NREQ, and moves to EXEC.
  - With no valid request, it stays in IDLE and `ptr` is unchanged.
- **EXEC**
  - The latched operands drive `Adder_Subtractor`.
  - At the end of the cycle, `result`, `exception` and the ID are registered into the `rsp_*` outputs.
  - `exc_count` increments if `exception` is set.
  - Next state is DONE.
- **DONE**
  - `rsp_valid` is 1 and all `rsp_*` outputs are held stable.
  - On `rsp_ready`, the next state is IDLE. Otherwise the block stays in DONE indefinitely.
- `req_ready` is all-zero in EXEC and DONE. Requesters hold `req_valid` and operands until accepted; the block never drops an asserted request.
- Fairness: any continuously asserted request is granted within NREQ accepted transactions.
- `req_valid` deasserting before acceptance is legal; the request is simply not granted.
- Arithmetic is entirely that of `Adder_Subtractor`. The block never modifies operands or result bits.

## Timing
- Reset (asynchronous, on `rst_n` low):
  - state = IDLE, `ptr` = 0.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_exception` = 0, `rsp_id` = 0.
  - `exc_count` = 0, `busy` = 0.
  - `req_ready` is then purely combinational from `req_valid`.
- Reset in EXEC or DONE discards the in-flight operation. No response is produced for it.
- Latency: accept edge at cycle T, state EXEC in T+1, `rsp_valid` high from T+2.
- Fastest possible rate is one transaction per 3 cycles, with `rsp_ready` held high.
- The cycle after the response handshake is IDLE. A new accept can occur in that cycle.
- A simultaneous new request and response handshake in DONE is not possible, because `req_ready` is 0 in DONE.
- `exc_count` updates in the same edge that loads `rsp_*`.
- Pointer wrap: a grant to NREQ−1 sets `ptr` = 0.

## Structure
- Package `fpu_pkg` contains:
  - `FP_W = 32`
  - `OP_ADD = 1'b0`, `OP_SUB = 1'b1`
  - `typedef enum logic [1:0] {IDLE, EXEC, DONE} fpu_arb_state_t`
  - `typedef struct packed {logic [31:0] a, b; logic op;} fpu_req_t`
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`.
  - Purely combinational. The pointer register lives in the parent.
- The parent instantiates `Adder_Subtractor` once. Operand registers, FSM and response registers are in the parent.

## Test plan
- **Reset values:** after reset, only `req_valid[2]` is high with A=0x40200000 (2.5), B=0x3E800000 (0.25), op=0.
  - `req_ready` = 0b0100.
  - `rsp_valid` rises 2 cycles after accept.
  - `rsp_result` = 0x40300000 (2.75), `rsp_id` = 2, `rsp_exception` = 0.
- **Subtract with backpressure:** requester 0 sends A=0x40600000 (3.5), B=0x3FA00000 (1.25), op=1, with `rsp_ready` low for 5 cycles.
  - `rsp_result` = 0x40100000, held stable.
  - `req_ready` stays 0 until the response handshake.
  - Returns to IDLE the following cycle.
- **Round-robin:** all four requesters held valid, `rsp_ready` = 1.
  - `rsp_id` sequence is 0,1,2,3,0,1.
  - Accepts occur exactly every 3 cycles.
- **Pointer skip and wrap:** only requesters 1 and 3 valid.
  - Grant order is 1,3,1,3.
  - `ptr` wraps to 0 after the grant to 3.
- **Exception count:** A=0x7F7FFFFF, B=0x7F7FFFFF, op=0, issued three times.
  - `rsp_exception` = 1 each time (overflow per `Adder_Subtractor`).
  - `exc_count` = 3.
- **Reset mid-operation:** assert `rst_n` low in the EXEC cycle.
  - No `rsp_valid` appears.
  - All outputs are at reset values.
  - The next request is served normally, with `ptr` = 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU add/sub front end.
package fpu_pkg;

    localparam int   FP_W   = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} fpu_arb_state_t;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            op;
    } fpu_req_t;

endpackage

// File: rtl/Adder_Subtractor.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// exception flags overflow to infinity, infinite operands and NaN results.
module Adder_Subtractor
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            op,
    output logic            exception,
    output logic [FP_W-1:0] result
);

    logic        sign_a, sign_b, sign_l, sign_s, swap, eff_sub;
    logic        a_inf, b_inf, a_nan, b_nan;
    logic [7:0]  exp_l, exp_s, diff;
    logic [23:0] man_l, man_s;
    logic [26:0] ext_s, sh_s, norm;
    logic [27:0] sum;
    logic [9:0]  exp_n;
    logic [4:0]  lz, sh;
    logic        lz_found, rnd_up;
    logic [24:0] man_r;

    // align, add, normalise, round, then pick special-case results
    always_comb begin
        sign_a = a[31];
        sign_b = b[31] ^ (op == OP_SUB);
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);

        // larger magnitude goes first so the difference is never negative
        swap = b[30:0] > a[30:0];
        if (swap) begin
            sign_l = sign_b;  sign_s = sign_a;
            exp_l  = b[30:23]; exp_s = a[30:23];
            man_l  = {|b[30:23], b[22:0]};
            man_s  = {|a[30:23], a[22:0]};
        end else begin
            sign_l = sign_a;  sign_s = sign_b;
            exp_l  = a[30:23]; exp_s = b[30:23];
            man_l  = {|a[30:23], a[22:0]};
            man_s  = {|b[30:23], b[22:0]};
        end
        // subnormals share the minimum normal exponent
        if (exp_l == 8'd0) exp_l = 8'd1;
        if (exp_s == 8'd0) exp_s = 8'd1;
        eff_sub = sign_l ^ sign_s;

        // three extra bits: guard, round, sticky
        diff  = exp_l - exp_s;
        ext_s = {man_s, 3'b000};
        if (diff >= 8'd27)
            sh_s = {26'd0, |ext_s};
        else
            sh_s = (ext_s >> diff) | {26'd0, |(ext_s & ((27'd1 << diff) - 27'd1))};

        if (eff_sub)
            sum = {1'b0, man_l, 3'b000} - {1'b0, sh_s};
        else
            sum = {1'b0, man_l, 3'b000} + {1'b0, sh_s};

        exp_n    = {2'b00, exp_l};
        lz       = 5'd0;
        lz_found = 1'b0;
        sh       = 5'd0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (!lz_found && sum[26-i]) begin
                    lz       = 5'(i);
                    lz_found = 1'b1;
                end
            end
            if (!lz_found) lz = 5'd27;
            // never shift below the minimum exponent: result goes subnormal
            sh    = ({5'd0, lz} < exp_n - 10'd1) ? lz : 5'(exp_n - 10'd1);
            norm  = sum[26:0] << sh;
            exp_n = exp_n - {5'd0, sh};
        end

        rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        man_r  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (man_r[24]) begin
            man_r = {1'b0, man_r[24:1]};
            exp_n = exp_n + 10'd1;
        end

        exception = 1'b0;
        if (a_nan | b_nan | (a_inf & b_inf & (sign_a != sign_b))) begin
            result    = 32'h7FC0_0000;
            exception = 1'b1;
        end else if (a_inf) begin
            result    = {sign_a, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (b_inf) begin
            result    = {sign_b, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (sum == 28'd0) begin
            // exact cancellation gives +0 unless both inputs were -0
            result = {sign_a & sign_b, 31'd0};
        end else if (exp_n >= 10'd255) begin
            result    = {sign_l, 8'hFF, 23'd0};
            exception = 1'b1;
        end else begin
            result = {sign_l, man_r[23] ? exp_n[7:0] : 8'd0, man_r[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // scan N positions starting from ptr; the first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin front end sharing one Adder_Subtractor among NREQ requesters.
// One transaction in flight: IDLE (accept) -> EXEC (compute) -> DONE (hold response).
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][FP_W-1:0] req_a,
    input  logic [NREQ-1:0][FP_W-1:0] req_b,
    input  logic [NREQ-1:0]           req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [FP_W-1:0]           rsp_result,
    output logic                      rsp_exception,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy,
    output logic [15:0]               exc_count
);

    fpu_arb_state_t  state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
    fpu_req_t        opr_q, opr_d;
    logic [NREQ-1:0] gnt;
    logic            accept;
    logic [FP_W-1:0] fu_result, rsp_result_q, rsp_result_d;
    logic            fu_exc, rsp_exc_q, rsp_exc_d;
    logic [15:0]     exc_cnt_q, exc_cnt_d;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    Adder_Subtractor u_addsub (
        .a         (opr_q.a),
        .b         (opr_q.b),
        .op        (opr_q.op),
        .exception (fu_exc),
        .result    (fu_result)
    );

    // sequencer: capture operands on accept, register the result, hold until taken
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        opr_d        = opr_q;
        rsp_result_d = rsp_result_q;
        rsp_exc_d    = rsp_exc_q;
        rsp_id_d     = rsp_id_q;
        exc_cnt_d    = exc_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opr_d   = '{a: req_a[gnt_idx], b: req_b[gnt_idx], op: req_op[gnt_idx]};
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = fu_result;
                rsp_exc_d    = fu_exc;
                rsp_id_d     = id_q;
                if (fu_exc && exc_cnt_q != 16'hFFFF)
                    exc_cnt_d = exc_cnt_q + 16'd1;
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            opr_q        <= '0;
            rsp_result_q <= '0;
            rsp_exc_q    <= 1'b0;
            rsp_id_q     <= '0;
            exc_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            opr_q        <= opr_d;
            rsp_result_q <= rsp_result_d;
            rsp_exc_q    <= rsp_exc_d;
            rsp_id_q     <= rsp_id_d;
            exc_cnt_q    <= exc_cnt_d;
        end
    end

    assign rsp_valid     = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign rsp_result    = rsp_result_q;
    assign rsp_exception = rsp_exc_q;
    assign rsp_id        = rsp_id_q;
    assign exc_count     = exc_cnt_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: directed corner sequences, a vector table and
// a randomized run against a cycle-count / queue reference model.
module tb_fpu_addsub_arbiter;
    import fpu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NREQ-1:0]           req_valid, req_ready, req_op;
    logic [NREQ-1:0][31:0]     req_a, req_b;
    logic                      rsp_valid, rsp_ready, rsp_exception, busy;
    logic [31:0]               rsp_result;
    logic [IDW-1:0]            rsp_id;
    logic [15:0]               exc_count;

    fpu_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_id(rsp_id),
        .busy(busy), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // exact single-precision encoding of a small integer
    function automatic logic [31:0] int2fp(input int v);
        int m, p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h7FFFFF);
        return r;
    endfunction

    function automatic int oh2idx(input logic [NREQ-1:0] oh);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    // one transaction from requester r, rsp_ready held high
    task automatic run_txn(input int r, input logic [31:0] a, input logic [31:0] b, input logic op,
                           output logic [31:0] res, output logic exc, output int id);
        int n;
        @(negedge clk);
        req_valid[r] = 1'b1; req_a[r] = a; req_b[r] = b; req_op[r] = op; rsp_ready = 1'b1;
        #1; n = 0;
        while (!req_ready[r] && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL accept_timeout: waited %0d cycles, limit 20", n); end
        @(negedge clk); req_valid[r] = 1'b0; #1; n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL rsp_timeout: waited %0d cycles, limit 20", n); end
        res = rsp_result; exc = rsp_exception; id = int'(rsp_id);
        @(negedge clk);
    endtask

    typedef struct { logic [31:0] a, b; logic op; logic [31:0] res; logic exc; } vec_t;
    vec_t tbl[10];

    // random-phase model state
    int          qa[NREQ][$], qb[NREQ][$];
    logic        qop[NREQ][$];
    int          sb_id[$];
    logic [31:0] sb_res[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        exc;
        int          id;
        int          rid[$], acc[$];
        int          exp_rr[6];
        int          exp_sw[4];
        int          last_g;
        int          inflight, age, mptr, acc_r, eidx, av, bv;
        logic [NREQ-1:0] exp_rdy;
        logic        done;

        rst_n = 1'b1;
        do_reset();

        // ---- reset values and first transaction
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_exc", rsp_exception, 0);
        chk("rst_exc_count", exc_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ptr", dut.ptr_q, 0);
        req_valid[2] = 1'b1; req_a[2] = 32'h40200000; req_b[2] = 32'h3E800000; req_op[2] = OP_ADD;
        #1 chk("rst_req_ready", req_ready, 4'b0100);
        @(negedge clk); req_valid[2] = 1'b0; #1;
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_ready", req_ready, 0);
        @(negedge clk); #1;
        chk("lat_rsp_valid", rsp_valid, 1);
        chk("first_result", rsp_result, 32'h40300000);
        chk("first_id", rsp_id, 2);
        chk("first_exc", rsp_exception, 0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("after_hs_busy", busy, 0);
        chk("after_hs_rsp_valid", rsp_valid, 0);
        rsp_ready = 1'b0;

        // ---- subtract with backpressure; requester 1 waits meanwhile
        req_valid[0] = 1'b1; req_a[0] = 32'h40600000; req_b[0] = 32'h3FA00000; req_op[0] = OP_SUB;
        #1 chk("bp_ready0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_a[1] = 32'h3F800000; req_b[1] = 32'h3F800000; req_op[1] = OP_ADD;
        #1 chk("bp_exec_ready", req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_result", rsp_result, 32'h40100000);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_ready", req_ready, 4'b0010);
        @(negedge clk); req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("bp_next_result", rsp_result, 32'h40000000);
        chk("bp_next_id", rsp_id, 1);
        @(negedge clk); rsp_ready = 1'b0;

        // ---- vector table through rotating requesters
        tbl[0] = '{32'h40200000, 32'h3E800000, OP_ADD, 32'h40300000, 1'b0};
        tbl[1] = '{32'h40600000, 32'h3FA00000, OP_SUB, 32'h40100000, 1'b0};
        tbl[2] = '{32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 1'b0};
        tbl[3] = '{32'hC0000000, 32'h3F000000, OP_ADD, 32'hBFC00000, 1'b0};
        tbl[4] = '{32'h3F800000, 32'h33800000, OP_ADD, 32'h3F800000, 1'b0};
        tbl[5] = '{32'h3F800000, 32'h34400000, OP_ADD, 32'h3F800002, 1'b0};
        tbl[6] = '{32'h00000001, 32'h00000001, OP_ADD, 32'h00000002, 1'b0};
        tbl[7] = '{32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 1'b1};
        tbl[8] = '{32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000, 1'b1};
        tbl[9] = '{32'h3F800000, 32'h40000000, OP_SUB, 32'hBF800000, 1'b0};
        for (int i = 0; i < 10; i++) begin
            run_txn(i % NREQ, tbl[i].a, tbl[i].b, tbl[i].op, res, exc, id);
            chk($sformatf("tbl_res[%0d]", i), res, tbl[i].res);
            chk($sformatf("tbl_exc[%0d]", i), exc, tbl[i].exc);
            chk($sformatf("tbl_id[%0d]", i), id, i % NREQ);
        end
        chk("tbl_exc_count", exc_count, 2);

        // ---- round-robin, all requesters valid
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = 1'b1; req_a[i] = int2fp(i + 1); req_b[i] = int2fp(10); req_op[i] = OP_ADD;
        end
        exp_rr = '{0, 1, 2, 3, 0, 1};
        for (int c = 0; c < 60 && rid.size() < 6; c++) begin
            #1;
            if (|(req_valid & req_ready)) acc.push_back(c);
            if (rsp_valid) begin
                rid.push_back(int'(rsp_id));
                chk("rr_result", rsp_result, int2fp(int'(rsp_id) + 11));
            end
            @(negedge clk);
        end
        chk("rr_count", rid.size(), 6);
        for (int i = 0; i < 6 && i < rid.size(); i++) chk($sformatf("rr_id[%0d]", i), rid[i], exp_rr[i]);
        for (int i = 1; i < acc.size() && i < 6; i++) chk("rr_interval", acc[i] - acc[i-1], 3);

        // ---- pointer skip and wrap, requesters 1 and 3 only
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        exp_sw = '{1, 3, 1, 3};
        rid.delete();
        last_g = -1;
        for (int c = 0; c < 60 && rid.size() < 4; c++) begin
            #1;
            if (last_g >= 0) begin
                chk("sw_ptr", dut.ptr_q, (last_g + 1) % NREQ);
                last_g = -1;
            end
            if (|(req_valid & req_ready)) begin
                last_g = oh2idx(req_ready);
                rid.push_back(last_g);
            end
            @(negedge clk);
        end
        #1 if (last_g >= 0) chk("sw_ptr", dut.ptr_q, (last_g + 1) % NREQ);
        chk("sw_count", rid.size(), 4);
        for (int i = 0; i < 4 && i < rid.size(); i++) chk($sformatf("sw_grant[%0d]", i), rid[i], exp_sw[i]);

        // ---- exception counting
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_txn(i, 32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, res, exc, id);
            chk("exc_flag", exc, 1);
            chk("exc_result", res, 32'h7F800000);
        end
        chk("exc_count3", exc_count, 3);

        // ---- reset during EXEC drops the operation
        @(negedge clk);
        req_valid[2] = 1'b1; req_a[2] = int2fp(5); req_b[2] = int2fp(6); req_op[2] = OP_ADD;
        @(negedge clk); req_valid[2] = 1'b0; #1;
        chk("mr_in_exec", busy, 1);
        rst_n = 1'b0; #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_result", rsp_result, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_exc_count", exc_count, 0);
        chk("mr_ptr", dut.ptr_q, 0);
        @(negedge clk); rst_n = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); #1; if (rsp_valid) done = 1'b1; end
        chk("mr_no_rsp", done, 0);
        req_valid = 4'b1010; req_a[1] = int2fp(7); req_b[1] = int2fp(2); req_op[1] = OP_SUB;
        #1 chk("mr_next_ready", req_ready, 4'b0010);
        @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("mr_next_result", rsp_result, int2fp(5));
        chk("mr_next_id", rsp_id, 1);

        // ---- randomized traffic against the reference model
        do_reset();
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < 6; k++) begin
                qa[r].push_back(int'($urandom_range(2000)) - 1000);
                qb[r].push_back(int'($urandom_range(2000)) - 1000);
                qop[r].push_back(1'($urandom_range(1)));
            end
        inflight = 0; age = 0; mptr = 0; acc_r = -1; done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (acc_r >= 0) begin req_valid[acc_r] = 1'b0; acc_r = -1; end
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r]) begin
                    if ($urandom_range(7) == 0) req_valid[r] = 1'b0;
                end else if (qa[r].size() != 0 && $urandom_range(1) == 1) begin
                    req_valid[r] = 1'b1;
                    req_a[r] = int2fp(qa[r][0]); req_b[r] = int2fp(qb[r][0]); req_op[r] = qop[r][0];
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            if (inflight != 0) age++;
            exp_rdy = '0; eidx = -1;
            if (inflight == 0)
                for (int k = 0; k < NREQ; k++)
                    if (eidx < 0 && req_valid[(mptr + k) % NREQ]) eidx = (mptr + k) % NREQ;
            if (eidx >= 0) exp_rdy[eidx] = 1'b1;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_rsp_valid", rsp_valid, (inflight != 0 && age >= 2));
            chk("rnd_busy", busy, (inflight != 0));
            if (inflight != 0 && age >= 2 && rsp_ready) begin
                chk("rnd_id", rsp_id, sb_id[0]);
                chk("rnd_result", rsp_result, sb_res[0]);
                chk("rnd_exc", rsp_exception, 0);
                void'(sb_id.pop_front()); void'(sb_res.pop_front());
                inflight = 0;
            end else if (eidx >= 0) begin
                av = qa[eidx].pop_front(); bv = qb[eidx].pop_front();
                sb_id.push_back(eidx);
                sb_res.push_back(int2fp(qop[eidx].pop_front() ? av - bv : av + bv));
                inflight = 1; age = 0; mptr = (eidx + 1) % NREQ; acc_r = eidx;
            end
            done = (inflight == 0) && (req_valid == '0) && (acc_r < 0);
            for (int r = 0; r < NREQ; r++) if (qa[r].size() != 0) done = 1'b0;
        end
        chk("rnd_drained", done, 1);
        chk("rnd_exc_count", exc_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
